// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and load/store (D).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise D has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
    end

    state_t     state, state_n;
    logic [3:0] cnt;
    logic       own_d, lat_we, pick_d, grant, last;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_d;
    assign pick_d = d_req && (!if_req || rr_d);
    always_ff @(posedge clk)
        if (!reset)
            rr_d <= 1'b1;
        else if (grant)
            rr_d <= !pick_d;
`else
    assign pick_d = d_req;
`endif

    assign grant = state == IDLE && (if_req || d_req);
    assign last  = state == ACCESS && cnt == 4'd0;

    always_comb begin
        state_n = IDLE;
        state_n = state == IDLE   ? (grant ? ACCESS : IDLE) :
                  state == ACCESS ? (last ? RESP : ACCESS) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            own_d     <= 1'b0;
            lat_we    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state  <= state_n;
            mem_en <= state_n == ACCESS;
            mem_we <= state_n == ACCESS && (grant ? pick_d && d_we : lat_we);
            busy   <= state_n != IDLE;
            if_ack <= last && !own_d;
            d_ack  <= last && own_d;
            if (grant) begin
                own_d    <= pick_d;
                lat_we   <= pick_d && d_we;
                mem_addr <= pick_d ? d_addr : if_addr;
                cnt      <= 4'(WAIT_CYCLES - 1);
                if (pick_d)
                    mem_wdata <= d_wdata;
            end else if (state == ACCESS && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            // read data is valid only at the end of the final access cycle
            if (last && !lat_we) begin
                if (own_d)
                    d_rdata <= mem_rdata;
                else
                    if_rdata <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table and corner sequences against a scoreboard of expected accesses.
module tb_mem_port_arbiter;
    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 0, reset = 0, init = 1;
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic        if_ack, d_ack, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        b_d_req = 0;
    logic [31:0] b_d_addr = 0;
    logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [31:0] mem [256];

    int   n_cmp = 0, n_bad = 0, en_cnt = 0;
    logic [31:0] exp_d = 0, exp_if = 0;
    txn_t q[$];
    txn_t vec[7];
    txn_t e;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .if_req(1'b0), .if_addr(32'h0), .if_ack(b_if_ack),
        .if_rdata(b_if_rdata), .d_req(b_d_req), .d_we(1'b0), .d_addr(b_d_addr), .d_wdata(32'h0),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy));

    assign mem_rdata   = mem[mem_addr[7:0]];
    assign b_mem_rdata = mem[b_mem_addr[7:0]];

    always @(posedge clk)
        if (init) begin
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h30] <= 32'hA5A50001;
            mem[8'h40] <= 32'h40400040;
            mem[8'h44] <= 32'h44440044;
            mem[8'h50] <= 32'hCAFEF00D;
        end else if (mem_en && mem_we)
            mem[mem_addr[7:0]] <= mem_wdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every enabled cycle must match the head access; each ack retires it.
    always @(posedge clk) begin
        #1;
        if (mem_we && !mem_en) chk("we_without_en", 1, 0);
        if (mem_en) begin
            en_cnt++;
            if (q.size() == 0) chk("mem_en_unexpected", 1, 0);
            else begin
                chk("mem_addr", mem_addr, q[0].addr);
                chk("mem_we", mem_we, q[0].is_d & q[0].we);
                if (q[0].is_d && q[0].we) chk("mem_wdata", mem_wdata, q[0].wdata);
            end
        end
        if (if_ack || d_ack) begin
            if (q.size() == 0) chk("spurious_ack", 1, 0);
            else begin
                e = q.pop_front();
                chk("ack_owner", {d_ack, if_ack}, e.is_d ? 2'b10 : 2'b01);
                chk("en_cycles", en_cnt, 2);
                if (e.is_d && !e.we) exp_d = e.rdata;
                if (!e.is_d) exp_if = e.rdata;
                chk("d_rdata", d_rdata, exp_d);
                chk("if_rdata", if_rdata, exp_if);
            end
            en_cnt = 0;
        end else if (!busy)
            en_cnt = 0;
    end

    task automatic drive_txn(input txn_t t);
        int lat = 0;
        @(negedge clk);
        if (t.is_d) begin
            d_req = 1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
        end else begin
            if_req = 1; if_addr = t.addr;
        end
        q.push_back(t);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (t.is_d ? d_ack : if_ack) begin lat = i; break; end
            if (i == 1) begin
                if_addr = 32'hFFFF_FFF0; d_addr = 32'hFFFF_FFE0; d_wdata = ~t.wdata; d_we = ~t.we;
            end
        end
        chk("latency", lat, 3);
        if_req = 0; d_req = 0;
        @(posedge clk);
    endtask

    task automatic wait_ack(input string nm, input bit is_d, input int exp_lat);
        int lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (is_d ? d_ack : if_ack) begin lat = i; break; end
        end
        chk(nm, lat, exp_lat);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 0;
        @(negedge clk); @(negedge clk); reset = 1;
        exp_d = 0; exp_if = 0;
    endtask

    task automatic run_both(input bit drop, input bit [3:0] ord);
        int acks = 0, d_rel = 0, i_rel = 0;
        for (int i = 0; i < 4; i++)
            q.push_back(ord[i] ? txn_t'{1, 0, 32'h44, 0, 32'h44440044} : txn_t'{0, 0, 32'h40, 0, 32'h40400040});
        @(negedge clk);
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h44;
        for (int c = 0; c < 80 && acks < 4; c++) begin
            @(posedge clk); #1;
            if (d_rel > 0) begin d_rel--; if (d_rel == 0) d_req = 1; end
            if (i_rel > 0) begin i_rel--; if (i_rel == 0) if_req = 1; end
            if (d_ack) begin acks++; if (drop) begin d_req = 0; d_rel = 2; end end
            if (if_ack) begin acks++; if (drop) begin if_req = 0; i_rel = 2; end end
        end
        if_req = 0; d_req = 0;
        chk("both_acks", acks, 4);
        @(posedge clk); #1;
        chk("both_queue_empty", q.size(), 0);
        @(posedge clk); #1;
        chk("both_idle_after", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{0, 0, 32'h10, 32'h0, 32'hDEADBEEF};
        vec[1] = '{1, 0, 32'h30, 32'h0, 32'hA5A50001};
        vec[2] = '{1, 1, 32'h20, 32'h12345678, 32'h0};
        vec[3] = '{1, 0, 32'h20, 32'h0, 32'h12345678};
        vec[4] = '{0, 0, 32'h20, 32'h0, 32'h12345678};
        vec[5] = '{1, 1, 32'h10, 32'h0BADF00D, 32'h0};
        vec[6] = '{0, 0, 32'h10, 32'h0, 32'h0BADF00D};

        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1; init = 0;
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);

        for (int i = 0; i < 7; i++) drive_txn(vec[i]);

        // reset while a load is in its first access cycle
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h30;
        q.push_back('{1, 0, 32'h30, 32'h0, 32'hA5A50001});
        @(posedge clk); #1;
        chk("abort_en_before", mem_en, 1);
        reset = 0;
        @(posedge clk); #1;
        chk("abort_mem_en", mem_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_d_ack", d_ack, 0);
        chk("abort_d_rdata", d_rdata, 0);
        reset = 1; exp_d = 0; exp_if = 0;
        wait_ack("abort_reissue_lat", 1, 3);
        d_req = 0;
        @(posedge clk);

        // held fetch request: exactly one idle cycle between back-to-back transactions
        @(negedge clk);
        if_req = 1; if_addr = 32'h10;
        q.push_back('{0, 0, 32'h10, 32'h0, 32'h0BADF00D});
        q.push_back('{0, 0, 32'h10, 32'h0, 32'h0BADF00D});
        wait_ack("held_first_lat", 0, 3);
        @(posedge clk); #1;
        chk("held_gap_en", mem_en, 0);
        chk("held_gap_busy", busy, 0);
        @(posedge clk); #1;
        chk("held_second_en", mem_en, 1);
        if_req = 0;
        wait_ack("held_second_lat", 0, 2);
        @(posedge clk);

        do_reset();
        run_both(1, 4'b0101);
`ifdef ARB_ROUND_ROBIN_EN
        run_both(0, 4'b0101);
`else
        run_both(0, 4'b1111);
`endif

        // single-cycle wait instance
        @(negedge clk);
        b_d_req = 1; b_d_addr = 32'h50;
        @(posedge clk); #1;
        chk("w1_en", b_mem_en, 1);
        chk("w1_addr", b_mem_addr, 32'h50);
        chk("w1_no_ack_yet", b_d_ack, 0);
        @(posedge clk); #1;
        chk("w1_en_off", b_mem_en, 0);
        chk("w1_d_ack", b_d_ack, 1);
        chk("w1_d_rdata", b_d_rdata, 32'hCAFEF00D);
        chk("w1_busy_resp", b_busy, 1);
        b_d_req = 0;
        @(posedge clk); #1;
        chk("w1_ack_once", b_d_ack, 0);
        chk("w1_if_ack", b_if_ack, 0);
        chk("w1_mem_we", b_mem_we, 0);
        chk("w1_if_rdata", b_if_rdata, 0);
        chk("w1_mem_wdata", b_mem_wdata, 0);
        chk("final_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data memory of the KGP-RISC multicycle datapath between two requesters: the instruction-fetch stage (IF) and the load/store stage (D). It sits between the stage logic sequenced by the main controller and the memory array. It arbitrates simultaneous requests, latches the winning access, and holds the memory enables for a fixed number of wait cycles. It then returns read data with a one-cycle acknowledge.

## Interface

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- WAIT_CYCLES, 2: cycles mem_en is held per access. Legal range is 1..15.

Ports:
- clk  in  1  sole clock; rising edge.
- reset  in  1  one clock; reset is synchronous and active-low.
- if_req  in  1  fetch request; level, held until if_ack.
- if_addr  in  ADDR_W  fetch address; sampled on grant.
- if_ack  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched word; held until next IF response.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1 = store, 0 = load; sampled on grant.
- d_addr  in  ADDR_W  data address; sampled on grant.
- d_wdata  in  DATA_W  store data; sampled on grant.
- d_ack  out  1  one-cycle pulse; load data valid / store complete.
- d_rdata  out  DATA_W  load word; held until next D load response.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable; only ever high while mem_en is high.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_rdata  in  DATA_W  memory read data; valid at the end of the last ACCESS cycle.
- busy  out  1  high in ACCESS and RESP.

## Operation

The state machine has three states: IDLE, ACCESS and RESP. All outputs are registered.

- **IDLE.** On an edge where if_req or d_req is sampled high:
  - select the owner;
  - latch the address, and for D also latch we and wdata;
  - load the counter with WAIT_CYCLES-1;
  - go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS.**
  - mem_en=1; mem_we=latched we when the owner is D, otherwise 0.
  - mem_addr and mem_wdata come from the latches.
  - The counter decrements each cycle.
  - On the edge where counter==0:
    - for a read, capture mem_rdata into the owner's rdata register;
    - go to RESP.
- **RESP.**
  - mem_en=0, mem_we=0.
  - The owner's ack is 1 for exactly this cycle.
  - Always return to IDLE.
- **Write responses.** For a store, d_ack pulses and d_rdata is unchanged.
- **Request rule.** The requester samples ack on the edge ending RESP. It must have req low, or a new request posted, by the following edge, which is the IDLE sampling edge. A req still high at that edge starts a new transaction.
- **Requester inputs.** Changes to addr, we or wdata after grant have no effect on the transaction in flight.
- **Counter width.** The counter is 4 bits. Behaviour for WAIT_CYCLES outside 1..15 is unsupported; the implementation flags it with an elaboration-time error.
- **Arbitration.** Simultaneous requests are resolved per the Configuration section. A single request is always granted.

## Timing

- **Latency.** Counting from the IDLE edge that samples req:
  - mem_en is high for cycles 1..WAIT_CYCLES;
  - ack is high in cycle WAIT_CYCLES+1.
- **Throughput.** At least one IDLE cycle separates transactions. Peak rate is one access per WAIT_CYCLES+2 cycles.
- **Reset values.** On the edge with reset=0:
  - state = IDLE and counter = 0;
  - mem_en, mem_we, if_ack, d_ack and busy are 0;
  - mem_addr, mem_wdata, if_rdata and d_rdata are 0;
  - the round-robin pointer selects D.
- **Reset mid-transaction.** The access is aborted: mem_en drops on the next cycle and no ack is issued. A req still high after reset release is granted as a fresh transaction.
- **Request dropped before ack.** Protocol violation. The transaction completes regardless.

## Configuration

- **ARB_ROUND_ROBIN_EN defined.** On simultaneous if_req and d_req in IDLE:
  - grant the side not granted last;
  - the pointer updates on every grant, including single-requester grants.
- **Not defined.** Fixed priority: D always wins simultaneous requests, and there is no pointer state.

## Test plan

1. **IF read.** WAIT_CYCLES=2; IF read at if_addr=0x10; memory returns 0xDEADBEEF.
   - Required: mem_en high for 2 cycles with mem_addr=0x10 and mem_we=0.
   - Required: if_ack pulses in cycle 3 with if_rdata=0xDEADBEEF; d_ack stays 0.
2. **D store.** d_addr=0x20, d_wdata=0x12345678, d_we=1.
   - Required: mem_en=mem_we=1 for 2 cycles with mem_addr=0x20 and mem_wdata=0x12345678.
   - Required: d_ack pulses; d_rdata keeps its prior value.
3. **Simultaneous requests.** if_req and d_req rise together and each is re-asserted after its ack.
   - Without macro: grant order D, IF, D, ...; whenever both are pending at IDLE, D wins.
   - With macro: from reset, D then IF, strictly alternating.
4. **Reset during ACCESS.** reset=0 in ACCESS cycle 1 with a D load.
   - Required: next cycle mem_en=0, busy=0, d_ack never pulses, d_rdata=0.
   - Required: with d_req held, the load re-executes after release.
5. **Held request.** if_req held high through ack and the following IDLE edge.
   - Required: a second IF transaction starts with exactly one IDLE cycle between them.
6. **WAIT_CYCLES=1.** D load of 0xCAFEF00D.
   - Required: mem_en high for 1 cycle and d_ack in cycle 2 with d_rdata=0xCAFEF00D.
